// File: rtl/intersection_scheduler.sv
// Two-way intersection light scheduler with actuated greens, yellow and all-red clearance.
// Optional pedestrian WALK phase is enabled with macro PED_WALK_EN.
module intersection_scheduler #(
    parameter int MIN_GREEN = 3,
    parameter int MAX_GREEN = 8,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1,
    parameter int WALK_T    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       ns_req,
    input  logic       ew_req,
    input  logic       ped_req,
    output logic       ns_g,
    output logic       ns_y,
    output logic       ns_r,
    output logic       ew_g,
    output logic       ew_y,
    output logic       ew_r,
    output logic       walk,
    output logic [2:0] phase
);

    localparam int M1   = (MIN_GREEN > MAX_GREEN) ? MIN_GREEN : MAX_GREEN;
    localparam int M2   = (YELLOW_T > ALLRED_T) ? YELLOW_T : ALLRED_T;
    localparam int M3   = (M1 > M2) ? M1 : M2;
    localparam int CMAX = (M3 > WALK_T) ? M3 : WALK_T;
    localparam int CW   = (CMAX < 2) ? 1 : $clog2(CMAX);

    typedef enum logic [2:0] {
        NS_G  = 3'd0,
        NS_Y  = 3'd1,
        RED_A = 3'd2,
        EW_G  = 3'd3,
        EW_Y  = 3'd4,
`ifdef PED_WALK_EN
        RED_B = 3'd5,
        WALK  = 3'd6
`else
        RED_B = 3'd5
`endif
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          green;
    logic          ped_pend;

`ifdef PED_WALK_EN
    logic          walk_to_ew;   // WALK was entered from RED_A, so EW gets the next green
    logic          walk_entry;

    assign walk_entry = (state_n == WALK) && (state != WALK);

    always_ff @(posedge clk) begin
        if (rst) begin
            ped_pend   <= 1'b0;
            walk_to_ew <= 1'b0;
        end else begin
            // a button press in the entry cycle still registers as a new request
            ped_pend <= ped_req | (ped_pend & ~walk_entry);
            if (walk_entry)
                walk_to_ew <= (state == RED_A);
        end
    end
`else
    logic unused_ped;
    assign unused_ped = ped_req;
    assign ped_pend   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= NS_G;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            NS_G: if (tick && cnt >= CW'(MIN_GREEN-1) && (ew_req | ped_pend) &&
                      (!ns_req || cnt >= CW'(MAX_GREEN-1)))
                      state_n = NS_Y;
            NS_Y: if (tick && cnt == CW'(YELLOW_T-1)) state_n = RED_A;
            RED_A: if (tick && cnt == CW'(ALLRED_T-1)) begin
`ifdef PED_WALK_EN
                       state_n = ped_pend ? WALK : EW_G;
`else
                       state_n = EW_G;
`endif
                   end
            EW_G: if (tick && cnt >= CW'(MIN_GREEN-1) && (ns_req | ped_pend) &&
                      (!ew_req || cnt >= CW'(MAX_GREEN-1)))
                      state_n = EW_Y;
            EW_Y: if (tick && cnt == CW'(YELLOW_T-1)) state_n = RED_B;
            RED_B: if (tick && cnt == CW'(ALLRED_T-1)) begin
`ifdef PED_WALK_EN
                       state_n = ped_pend ? WALK : NS_G;
`else
                       state_n = NS_G;
`endif
                   end
`ifdef PED_WALK_EN
            WALK: if (tick && cnt == CW'(WALK_T-1)) state_n = walk_to_ew ? EW_G : NS_G;
`endif
            default: state_n = NS_G;
        endcase
    end

    assign green = (state == NS_G) || (state == EW_G);

    // greens saturate so an unopposed green can hold forever without wrapping
    always_comb begin
        cnt_n = cnt;
        if (state_n != state)
            cnt_n = '0;
        else if (tick && !(green && cnt >= CW'(MAX_GREEN-1)))
            cnt_n = cnt + CW'(1);
    end

    always_comb begin
        ns_g = 1'b0; ns_y = 1'b0; ns_r = 1'b1;
        ew_g = 1'b0; ew_y = 1'b0; ew_r = 1'b1;
        walk = 1'b0;
        case (state)
            NS_G: begin ns_g = 1'b1; ns_r = 1'b0; end
            NS_Y: begin ns_y = 1'b1; ns_r = 1'b0; end
            EW_G: begin ew_g = 1'b1; ew_r = 1'b0; end
            EW_Y: begin ew_y = 1'b1; ew_r = 1'b0; end
`ifdef PED_WALK_EN
            WALK: walk = 1'b1;
`endif
            default: ;
        endcase
    end

    assign phase = state;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Bench for intersection_scheduler: directed tables, timing sequences and a randomized
// run against a duration-based reference model.
module tb_intersection_scheduler;

    localparam int MIN_GREEN = 3, MAX_GREEN = 8, YELLOW_T = 2, ALLRED_T = 1, WALK_T = 4;
    localparam logic [5:0] L_NSG = 6'b100001, L_NSY = 6'b010001, L_RED = 6'b001001,
                           L_EWG = 6'b001100, L_EWY = 6'b001010;

    logic clk = 1'b0;
    logic rst, tick, ns_req, ew_req, ped_req;
    logic ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk;
    logic [2:0] phase;

    int passed = 0, total = 0;

    // reference model: phase index 0..6 in listed order, ticks elapsed in phase
    int m_st = 0, m_el = 0, m_after = 0;
    bit m_pend = 0;

    intersection_scheduler #(
        .MIN_GREEN(MIN_GREEN), .MAX_GREEN(MAX_GREEN), .YELLOW_T(YELLOW_T),
        .ALLRED_T(ALLRED_T), .WALK_T(WALK_T)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .ns_req(ns_req), .ew_req(ew_req),
        .ped_req(ped_req), .ns_g(ns_g), .ns_y(ns_y), .ns_r(ns_r), .ew_g(ew_g),
        .ew_y(ew_y), .ew_r(ew_r), .walk(walk), .phase(phase)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] lamps_of(input int s);
        case (s)
            0: return L_NSG;
            1: return L_NSY;
            3: return L_EWG;
            4: return L_EWY;
            default: return L_RED;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    task automatic model_clk();
        int nxt, e;
        if (rst) begin
            m_st = 0; m_el = 0; m_pend = 0; m_after = 0;
            return;
        end
        nxt = m_st;
        e = m_el + 1;
        if (tick) begin
            case (m_st)
                0: if (e >= MIN_GREEN && (ew_req || m_pend) && (!ns_req || e >= MAX_GREEN)) nxt = 1;
                1: if (e == YELLOW_T) nxt = 2;
                2: if (e == ALLRED_T) begin
                       if (m_pend) begin nxt = 6; m_after = 3; end else nxt = 3;
                   end
                3: if (e >= MIN_GREEN && (ns_req || m_pend) && (!ew_req || e >= MAX_GREEN)) nxt = 4;
                4: if (e == YELLOW_T) nxt = 5;
                5: if (e == ALLRED_T) begin
                       if (m_pend) begin nxt = 6; m_after = 0; end else nxt = 0;
                   end
                6: if (e == WALK_T) nxt = m_after;
                default: nxt = 0;
            endcase
        end
`ifdef PED_WALK_EN
        if (nxt == 6 && m_st != 6) m_pend = ped_req;
        else m_pend = m_pend | ped_req;
`else
        m_pend = 0;
`endif
        if (nxt != m_st) m_el = 0;
        else if (tick) m_el = e;
        m_st = nxt;
    endtask

    // one clk: drive inputs, let model follow the edge, compare on the falling edge
    task automatic cyc(input bit r, input bit t, input bit n, input bit e, input bit p);
        rst = r; tick = t; ns_req = n; ew_req = e; ped_req = p;
        @(posedge clk);
        model_clk();
        @(negedge clk);
        check("model", {22'd0, ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk, phase},
              {22'd0, lamps_of(m_st), (m_st == 6), 3'(m_st)});
        check("lamp_invariant", {29'd0, $onehot({ns_g, ns_y, ns_r}), $onehot({ew_g, ew_y, ew_r}),
              !(ns_g && ew_g)}, 32'd7);
    endtask

    typedef struct {
        bit r, t, n, e, p;
        int ph;
        logic [5:0] lamps;
    } vec_t;

    vec_t tbl[11];
    int pre[$];
    int run_len[$], run_ph[$];
    int exp_len[7] = '{8, 2, 1, 8, 2, 1, 8};
    int exp_ph[7]  = '{0, 1, 2, 3, 4, 5, 0};
`ifdef PED_WALK_EN
    int ped_seq[10] = '{0, 1, 1, 2, 6, 6, 6, 6, 3, 3};
`else
    int ped_seq[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`endif

    initial begin
        tbl[0]  = '{1, 0, 0, 1, 0, 0, L_NSG};
        tbl[1]  = '{0, 1, 0, 1, 0, 0, L_NSG};
        tbl[2]  = '{0, 1, 0, 1, 0, 0, L_NSG};
        tbl[3]  = '{0, 1, 0, 1, 0, 1, L_NSY};
        tbl[4]  = '{0, 1, 0, 1, 0, 1, L_NSY};
        tbl[5]  = '{0, 1, 0, 1, 0, 2, L_RED};
        tbl[6]  = '{0, 1, 0, 1, 0, 3, L_EWG};
        tbl[7]  = '{0, 1, 0, 1, 0, 3, L_EWG};
        tbl[8]  = '{0, 1, 0, 1, 0, 3, L_EWG};
        tbl[9]  = '{0, 1, 0, 0, 0, 3, L_EWG};
        tbl[10] = '{1, 1, 1, 1, 1, 0, L_NSG};

        rst = 1; tick = 0; ns_req = 0; ew_req = 0; ped_req = 0;

        // table: reset, EW demand timing, unopposed EW hold, reset overriding tick
        for (int i = 0; i < 11; i++) begin
            cyc(tbl[i].r, tbl[i].t, tbl[i].n, tbl[i].e, tbl[i].p);
            check($sformatf("tbl%0d_phase", i), 32'(phase), 32'(tbl[i].ph));
            check($sformatf("tbl%0d_lamps", i), {26'd0, ns_g, ns_y, ns_r, ew_g, ew_y, ew_r},
                  {26'd0, tbl[i].lamps});
            cyc(0, 0, tbl[i].n, tbl[i].e, 0);
            check($sformatf("tbl%0d_hold", i), 32'(phase), 32'(tbl[i].ph));
        end

        // no requests: NS green for 20 ticks
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            cyc(0, 1, 0, 0, 0);
            check("idle_ns_g", {29'd0, ns_g, walk, phase == 3'd0}, 32'b101);
        end

        // both directions saturated: phase durations in ticks
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 40; i++) begin
            pre.push_back(int'(phase));
            cyc(0, 1, 1, 1, 0);
            cyc(0, 0, 1, 1, 0);
        end
        foreach (pre[i]) begin
            if (i == 0 || pre[i] != pre[i-1]) begin
                run_ph.push_back(pre[i]);
                run_len.push_back(1);
            end else run_len[run_len.size()-1]++;
        end
        check("cycle_runs", 32'(run_len.size() >= 8), 32'd1);
        for (int i = 0; i < 7; i++) begin
            if (i < run_len.size()) begin
                check($sformatf("run%0d_len", i), 32'(run_len[i]), 32'(exp_len[i]));
                check($sformatf("run%0d_phase", i), 32'(run_ph[i]), 32'(exp_ph[i]));
            end
        end

        // pedestrian pulse during first NS green tick
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 1, 0, 0, 0);
            check($sformatf("ped_t%0d_phase", i + 2), 32'(phase), 32'(ped_seq[i]));
            check($sformatf("ped_t%0d_walk", i + 2), 32'(walk), 32'(ped_seq[i] == 6));
        end

        // reset coincident with tick while EW yellow has cnt=1
        begin
            bit found = 0;
            cyc(1, 0, 0, 0, 0);
            for (int i = 0; i < 60 && !found; i++) begin
                cyc(0, 1, 1, 1, 0);
                if (m_st == 4 && m_el == 1) found = 1;
            end
            check("ewy_reached", 32'(found), 32'd1);
            check("ewy_lamp_before", 32'(ew_y), 32'(found));
            cyc(1, 1, 1, 1, 0);
            check("rst_ewy_phase", 32'(phase), 32'd0);
            check("rst_ewy_lamps", {26'd0, ns_g, ns_y, ns_r, ew_g, ew_y, ew_r}, {26'd0, L_NSG});
            cyc(0, 1, 1, 1, 0);
            check("rst_ewy_cnt0", 32'(phase), 32'd0);
        end

        // randomized traffic against the model
        begin
            bit n = 0, e = 0;
            cyc(1, 0, 0, 0, 0);
            for (int i = 0; i < 4000; i++) begin
                if ($urandom_range(0, 7) == 0) n = ~n;
                if ($urandom_range(0, 7) == 0) e = ~e;
                cyc($urandom_range(0, 299) == 0, $urandom_range(0, 2) == 0, n, e,
                    $urandom_range(0, 24) == 0);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
